// File: rtl/mips_core_pkg.sv
// Shared rename-stage constants and types for the MIPS core.
package mips_core_pkg;

    localparam int PHYS_REG_COUNT = 64;
    localparam int ARCH_REG_COUNT = 32;
    localparam int PHYS_TAG_WIDTH = 6;

    typedef logic [PHYS_TAG_WIDTH-1:0] phys_tag_t;

    typedef enum logic [0:0] {
        FL_INIT = 1'b0,
        FL_RUN  = 1'b1
    } free_list_state_e;

endpackage

// File: rtl/free_list_bitmap.sv
// One bit per physical tag recording whether that tag currently sits in the free list.
module free_list_bitmap #(
    parameter int PHYS_REGS = 64,
    parameter int TAG_W     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             set_en,
    input  logic [TAG_W-1:0] set_tag,
    input  logic             clr_en,
    input  logic [TAG_W-1:0] clr_tag,
    input  logic [TAG_W-1:0] query_tag,
    output logic             query_hit
);

    logic [PHYS_REGS-1:0] in_list;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_list <= '0;
        end else if (clear) begin
            in_list <= '0;
        end else begin
            // Set after clear so an enqueue of a tag always wins its own bit.
            if (clr_en) in_list[clr_tag] <= 1'b0;
            if (set_en) in_list[set_tag] <= 1'b1;
        end
    end

    assign query_hit = in_list[query_tag];

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags with an INIT refill sequencer.
// Optional duplicate-release detection is enabled by defining FREE_LIST_DUP_CHECK_EN.
module phys_reg_free_list
    import mips_core_pkg::*;
#(
    parameter int PHYS_REGS = PHYS_REG_COUNT,
    parameter int ARCH_REGS = ARCH_REG_COUNT,
    parameter int TAG_W     = PHYS_TAG_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             rel_valid,
    input  logic [TAG_W-1:0] rel_tag,
    output logic             ready,
    output logic [TAG_W:0]   free_count,
    output logic             empty,
    output logic             err_overflow
`ifdef FREE_LIST_DUP_CHECK_EN
    ,
    output logic             err_dup
`endif
);

    localparam logic [TAG_W-1:0] TAG_ONE    = TAG_W'(1);
    localparam logic [TAG_W:0]   COUNT_ONE  = (TAG_W+1)'(1);
    localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(PHYS_REGS);
    localparam logic [TAG_W-1:0] INIT_LAST  = TAG_W'(PHYS_REGS - ARCH_REGS - 1);
    localparam logic [TAG_W-1:0] INIT_BASE  = TAG_W'(ARCH_REGS);

    free_list_state_e state;
    logic [TAG_W-1:0] mem [PHYS_REGS];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W-1:0] init_idx;
    logic [TAG_W:0]   count;

    logic             run;
    logic             init_write;
    logic [TAG_W-1:0] init_tag;
    logic             rel_live;
    logic             rel_ok;
    logic             rel_full;
    logic             dup_hit;

    assign run        = (state == FL_RUN);
    assign init_write = (state == FL_INIT) && !flush;
    assign init_tag   = INIT_BASE + init_idx;

    // Tag 0 and anything arriving during INIT or flush never reach the list.
    assign rel_live  = run && !flush && rel_valid && (rel_tag != '0);
    assign rel_ok    = rel_live && (count != FULL_COUNT) && !dup_hit;
    assign rel_full  = rel_live && (count == FULL_COUNT);
    assign alloc_gnt = run && !flush && alloc_req && (count != '0);

    assign alloc_tag  = run ? mem[head] : '0;
    assign ready      = run;
    assign free_count = count;
    assign empty      = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FL_INIT;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            init_idx <= '0;
        end else if (flush) begin
            state    <= FL_INIT;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            init_idx <= '0;
        end else if (state == FL_INIT) begin
            tail     <= tail + TAG_ONE;
            count    <= count + COUNT_ONE;
            init_idx <= init_idx + TAG_ONE;
            if (init_idx == INIT_LAST) state <= FL_RUN;
        end else begin
            if (alloc_gnt) head <= head + TAG_ONE;
            if (rel_ok)    tail <= tail + TAG_ONE;
            case ({alloc_gnt, rel_ok})
                2'b10:   count <= count - COUNT_ONE;
                2'b01:   count <= count + COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow <= 1'b0;
        end else if (rel_full) begin
            err_overflow <= 1'b1;
        end
    end

    // Storage carries no reset; only entries between head and tail are ever read as valid.
    always_ff @(posedge clk) begin
        if (init_write) begin
            mem[init_idx] <= init_tag;
        end else if (rel_ok) begin
            mem[tail] <= rel_tag;
        end
    end

`ifdef FREE_LIST_DUP_CHECK_EN
    logic             bm_hit;
    logic             bm_set_en;
    logic [TAG_W-1:0] bm_set_tag;

    assign bm_set_en  = init_write || rel_ok;
    assign bm_set_tag = init_write ? init_tag : rel_tag;
    assign dup_hit    = bm_hit;

    free_list_bitmap #(
        .PHYS_REGS (PHYS_REGS),
        .TAG_W     (TAG_W)
    ) u_bitmap (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .set_en    (bm_set_en),
        .set_tag   (bm_set_tag),
        .clr_en    (alloc_gnt),
        .clr_tag   (alloc_tag),
        .query_tag (rel_tag),
        .query_hit (bm_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_dup <= 1'b0;
        end else if (rel_live && bm_hit) begin
            err_dup <= 1'b1;
        end
    end
`else
    assign dup_hit = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: INIT, drain, empty release, wrap, overflow, flush.
module tb_phys_reg_free_list;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [5:0] alloc_tag;
    logic       rel_valid;
    logic [5:0] rel_tag;
    logic       ready;
    logic [6:0] free_count;
    logic       empty;
    logic       err_overflow;
`ifdef FREE_LIST_DUP_CHECK_EN
    logic       err_dup;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       alloc_req;
        logic       rel_valid;
        logic [5:0] rel_tag;
        logic       exp_gnt;
        logic       chk_tag;
        logic [5:0] exp_tag;
        logic [6:0] exp_count;
        logic       exp_empty;
    } vec_t;

    vec_t vecs [5];

    phys_reg_free_list dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_tag    (alloc_tag),
        .rel_valid    (rel_valid),
        .rel_tag      (rel_tag),
        .ready        (ready),
        .free_count   (free_count),
        .empty        (empty),
        .err_overflow (err_overflow)
`ifdef FREE_LIST_DUP_CHECK_EN
        ,
        .err_dup      (err_dup)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        alloc_req = 1'b0;
        rel_valid = 1'b0;
        rel_tag   = 6'd0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 6'd10, 1'b0, 1'b0, 6'd0,  7'd0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 6'd11, 1'b1, 1'b1, 6'd10, 7'd1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 6'd0,  1'b0, 1'b1, 6'd11, 7'd1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 6'd0,  1'b1, 1'b1, 6'd11, 7'd1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 6'd0,  7'd0, 1'b1};

        // Reset state
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_gnt", alloc_gnt, 0);
        chk("rst_tag", alloc_tag, 0);
        chk("rst_count", free_count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ovf", err_overflow, 0);
`ifdef FREE_LIST_DUP_CHECK_EN
        chk("rst_dup", err_dup, 0);
`endif
        rst_n = 1'b1;

        // INIT: 32 refill cycles
        for (int k = 0; k < 32; k++) begin
            chk("init_ready", ready, 0);
            chk("init_count", free_count, k);
            tick();
        end
        #1;
        chk("run_ready", ready, 1);
        chk("run_count", free_count, 32);
        chk("run_tag", alloc_tag, 32);

        // Drain 32 tags, then one refused request
        alloc_req = 1'b1;
        for (int i = 0; i <= 32; i++) begin
            #1;
            chk("drain_count", free_count, 32 - i);
            if (i < 32) begin
                chk("drain_gnt", alloc_gnt, 1);
                chk("drain_tag", alloc_tag, 32 + i);
            end else begin
                chk("drain_gnt_empty", alloc_gnt, 0);
                chk("drain_empty", empty, 1);
            end
            tick();
        end

        // Release into an empty list is not bypassed
        alloc_req = 1'b1;
        rel_valid = 1'b1;
        rel_tag   = 6'd5;
        #1;
        chk("empty_rel_gnt", alloc_gnt, 0);
        tick();
        rel_valid = 1'b0;
        #1;
        chk("empty_rel_next_gnt", alloc_gnt, 1);
        chk("empty_rel_next_tag", alloc_tag, 5);
        chk("empty_rel_next_count", free_count, 1);
        tick();
        alloc_req = 1'b0;
        #1;
        chk("empty_again", empty, 1);

        // Table: simultaneous grant/release and tag-0 drop
        for (int v = 0; v < 5; v++) begin
            alloc_req = vecs[v].alloc_req;
            rel_valid = vecs[v].rel_valid;
            rel_tag   = vecs[v].rel_tag;
            #1;
            chk($sformatf("vec%0d_gnt", v), alloc_gnt, vecs[v].exp_gnt);
            if (vecs[v].chk_tag) chk($sformatf("vec%0d_tag", v), alloc_tag, vecs[v].exp_tag);
            chk($sformatf("vec%0d_count", v), free_count, vecs[v].exp_count);
            chk($sformatf("vec%0d_empty", v), empty, vecs[v].exp_empty);
            tick();
        end
        idle_inputs();

        // Flush in RUN discards concurrent traffic
        flush     = 1'b1;
        alloc_req = 1'b1;
        rel_valid = 1'b1;
        rel_tag   = 6'd9;
        vecs[0].rel_tag = 6'd0;
        #1;
        chk("flush_gnt", alloc_gnt, 0);
        tick();
        idle_inputs();
        #1;
        chk("flush_ready", ready, 0);
        chk("flush_count", free_count, 0);

        // Flush again at INIT cycle 10
        for (int k = 0; k < 10; k++) tick();
        #1;
        chk("midinit_count", free_count, 10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("midinit_flush_count", free_count, 0);
        chk("midinit_flush_ready", ready, 0);
        for (int k = 0; k < 32; k++) begin
            chk("reinit_ready", ready, 0);
            tick();
        end
        #1;
        chk("reinit_ready_up", ready, 1);
        chk("reinit_count", free_count, 32);
        chk("reinit_tag", alloc_tag, 32);

`ifndef FREE_LIST_DUP_CHECK_EN
        // Fill to 64, overflow, tag 0 ignored, wrap-around drain
        rel_valid = 1'b1;
        for (int t = 1; t <= 32; t++) begin
            rel_tag = 6'(t);
            tick();
        end
        rel_valid = 1'b0;
        #1;
        chk("full_count", free_count, 64);
        chk("full_empty", empty, 0);
        chk("full_ovf_pre", err_overflow, 0);
        rel_valid = 1'b1;
        rel_tag   = 6'd7;
        tick();
        rel_tag = 6'd0;
        #1;
        chk("ovf_set", err_overflow, 1);
        chk("ovf_count", free_count, 64);
        tick();
        rel_valid = 1'b0;
        #1;
        chk("zero_rel_count", free_count, 64);
        chk("ovf_sticky", err_overflow, 1);
        alloc_req = 1'b1;
        #1;
        chk("full_gnt", alloc_gnt, 1);
        chk("full_tag", alloc_tag, 32);
        tick();
        alloc_req = 1'b0;
        rel_valid = 1'b1;
        rel_tag   = 6'd50;
        #1;
        chk("after_gnt_count", free_count, 63);
        tick();
        rel_valid = 1'b0;
        #1;
        chk("refull_count", free_count, 64);
        alloc_req = 1'b1;
        for (int i = 0; i < 64; i++) begin
            #1;
            chk("wrap_gnt", alloc_gnt, 1);
            if (i < 31)      chk("wrap_tag", alloc_tag, 33 + i);
            else if (i < 63) chk("wrap_tag", alloc_tag, i - 30);
            else             chk("wrap_tag", alloc_tag, 50);
            tick();
        end
        alloc_req = 1'b0;
        #1;
        chk("wrap_empty", empty, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush_keeps_ovf", err_overflow, 1);
        chk("flush_after_ovf_count", free_count, 0);
`else
        // Duplicate release detection
        alloc_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("dup_gnt", alloc_gnt, 1);
            chk("dup_tag", alloc_tag, 32 + i);
            tick();
        end
        alloc_req = 1'b0;
        #1;
        chk("dup_pre_count", free_count, 23);
        rel_valid = 1'b1;
        rel_tag   = 6'd40;
        tick();
        #1;
        chk("dup_first_count", free_count, 24);
        chk("dup_first_err", err_dup, 0);
        tick();
        rel_valid = 1'b0;
        #1;
        chk("dup_second_count", free_count, 24);
        chk("dup_second_err", err_dup, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Tracks which of the 64 physical registers behind the renamed register file are free to allocate.
- Sits between register rename (allocate port) and commit/write-back retirement (release port).
- Circular FIFO of physical tags, with an init sequencer that refills the list after reset or a flush.
- Guarantees phys reg 0 is never handed out or returned.

Parameters:
- PHYS_REGS, 64, number of physical registers; power of two.
- ARCH_REGS, 32, architectural registers; phys 0..ARCH_REGS-1 are identity-mapped at reset and never initially free.
- TAG_W, 6, log2(PHYS_REGS).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous restart; list returns to the reset contents via INIT
- alloc_req  in  1  rename requests one free tag this cycle
- alloc_gnt  out  1  request accepted; alloc_tag valid this cycle
- alloc_tag  out  TAG_W  tag at the head of the list
- rel_valid  in  1  retirement returns one tag
- rel_tag  in  TAG_W  tag being returned
- ready  out  1  high in RUN state
- free_count  out  TAG_W+1  number of tags currently in the list
- empty  out  1  free_count==0
- err_overflow  out  1  sticky; a release was attempted while the list was full

Behaviour:
- Storage: mem[PHYS_REGS] of TAG_W, head and tail pointers (TAG_W, wrap mod PHYS_REGS), count (TAG_W+1).
- Async reset: state=INIT, init_idx=0, head=0, tail=0, count=0, err_overflow=0. All outputs read 0 except empty=1.
- INIT state:
  - Each cycle writes mem[init_idx]=ARCH_REGS+init_idx, then increments tail, count and init_idx.
  - After PHYS_REGS-ARCH_REGS writes (32 cycles), moves to RUN.
  - ready=0 and alloc_gnt=0 throughout; releases are ignored.
- RUN state:
  - ready=1.
  - alloc_tag=mem[head] combinationally.
  - alloc_gnt = alloc_req && count!=0. On a grant, head++ and count-- at the next edge. Zero-cycle latency from request to grant.
  - Release: if rel_valid && rel_tag!=0 && count<PHYS_REGS, then mem[tail]=rel_tag, tail++, count++.
  - Release with rel_tag==0: silently dropped.
  - Release while count==PHYS_REGS: dropped and err_overflow set.
- Simultaneous grant and release: count unchanged, both pointers advance.
- Released tags are never bypassed to alloc_tag in the same cycle. When empty, a same-cycle release does not produce a grant; the tag is grantable from the next cycle.
- Wrap-around: pointers roll over from 63 to 0 with no special case.
- flush (any state, including mid-INIT):
  - Next edge: head=tail=count=init_idx=0, state=INIT.
  - Concurrent alloc/release that cycle is discarded; alloc_gnt is forced 0 while flush=1.
  - err_overflow is preserved; only rst_n clears it.
- free_count and empty are registered-state derived; they update the cycle after the event.

Optional Feature:
- Macro FREE_LIST_DUP_CHECK_EN.
- Defined:
  - Adds a PHYS_REGS-bit in_list bitmap, set on enqueue (INIT or release) and cleared on grant.
  - A release whose tag already has its in_list bit set is dropped and sets a sticky err_dup output (port exists only when the macro is defined).
  - Bitmap clears on reset and flush.
- Undefined: no bitmap, no err_dup port; duplicate releases are enqueued unchecked.

Decomposition:
- Shared package mips_core_pkg:
  - PHYS_REG_COUNT, ARCH_REG_COUNT, PHYS_TAG_WIDTH constants.
  - phys_tag_t typedef.
  - free_list_state_e enum {FL_INIT, FL_RUN}.
- One natural sub-module, free_list_bitmap: the duplicate-check bitmap, instantiated only under FREE_LIST_DUP_CHECK_EN.

Test Plan:
- Reset then idle 32 cycles -> ready=0 during INIT, ready=1 on cycle 33, free_count=32, alloc_tag=32.
- alloc_req held 33 cycles from RUN -> grants return tags 32..63 in order; 33rd cycle alloc_gnt=0; empty=1.
- List empty; rel_tag=5 with alloc_req the same cycle -> alloc_gnt=0; next cycle alloc_gnt=1 with alloc_tag=5.
- Fill to 64 by releasing 32 extra tags, then release tag 7 -> dropped, err_overflow=1, free_count stays 64; a following rel_tag=0 is ignored.
- flush asserted at INIT cycle 10 -> INIT restarts, ready after 32 more cycles, first alloc_tag=32.
- With FREE_LIST_DUP_CHECK_EN: grant tag 40, release 40 twice -> first enqueued, second dropped, err_dup=1.
